// File: rtl/mips_cpu_bus_lsu.sv
// mips_cpu_bus_lsu: load/store bus initiator turning byte-addressed core requests into aligned, byte-enabled word transfers
module mips_cpu_bus_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;
  state_t state, state_next;
  logic [2:0] op;
  logic [1:0] off;
  logic [3:0] lanes;
  logic accept, in_word, in_half, in_bad, is_store;
  logic [31:0] shifted;
  assign accept = req_valid && req_ready;
  assign in_word = req_op == 3'd0 || req_op == 3'd5;
  assign in_half = req_op == 3'd1 || req_op == 3'd2 || req_op == 3'd6;
  assign in_bad = in_word ? req_addr[1:0] != 2'b00 : in_half && req_addr[0];
  assign is_store = op >= 3'd5;
  assign shifted = readdata >> {off, 3'b000};
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  // next-state and bus handshake outputs; bus strobes only live in REQ
  always_comb begin
    state_next = state;
    req_ready = 1'b0;
    read = 1'b0;
    write = 1'b0;
    byteenable = 4'b0000;
    done = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept && !in_bad) state_next = REQ;
      end
      REQ: begin
        read = !is_store;
        write = is_store;
        byteenable = lanes;
        if (!waitrequest) state_next = is_store ? FIN : RESP;
      end
      RESP: state_next = FIN;
      default: begin
        done = 1'b1;
        state_next = IDLE;
      end
    endcase
  end
  // latch request on accept, flag misalignment, capture and extend load data in RESP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op <= 3'd0;
      off <= 2'd0;
      lanes <= 4'd0;
      address <= '0;
      writedata <= 32'd0;
      misalign <= 1'b0;
      load_data <= 32'd0;
    end else begin
      misalign <= accept && in_bad;
      if (accept && !in_bad) begin
        op <= req_op;
        off <= req_addr[1:0];
        address <= {req_addr[ADDR_W-1:2], 2'b00};
        lanes <= in_word ? 4'hf : in_half ? (req_addr[1] ? 4'hc : 4'h3) : 4'b0001 << req_addr[1:0];
        writedata <= in_word ? req_wdata : in_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
      end
      if (state == RESP)
        load_data <= op == 3'd3 ? {{24{shifted[7]}}, shifted[7:0]} :
                     op == 3'd4 ? {24'd0, shifted[7:0]} :
                     op == 3'd1 ? {{16{shifted[15]}}, shifted[15:0]} :
                     op == 3'd2 ? {16'd0, shifted[15:0]} : shifted;
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// tb_mips_cpu_bus_lsu: directed and random load/store transfers checked against a byte-lane reference model
module tb_mips_cpu_bus_lsu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic done, misalign, read, write;
  logic [31:0] load_data, address, writedata;
  logic [3:0] byteenable;
  logic waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  int n_chk = 0;
  int n_fail = 0;

  mips_cpu_bus_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .load_data(load_data), .misalign(misalign), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int s);
    int n, k, lat;
    logic st, bad, sgn;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, exp_ld, mask;
    n = (o == 3'd0 || o == 3'd5) ? 4 : (o == 3'd1 || o == 3'd2 || o == 3'd6) ? 2 : 1;
    k = int'(a[1:0]);
    st = o >= 3'd5;
    sgn = o == 3'd1 || o == 3'd3;
    bad = (k % n) != 0;
    exp_be = 4'(((1 << n) - 1) << k);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    mask = (n == 4) ? 32'hffff_ffff : 32'((1 << (8 * n)) - 1);
    exp_ld = (rd >> (8 * k)) & mask;
    if (sgn && exp_ld[8*n-1]) exp_ld = exp_ld | ~mask;
    @(posedge clk) #1;
    req_valid = 1'b1; req_op = o; req_addr = a; req_wdata = wd;
    waitrequest = s > 0; readdata = $urandom;
    @(negedge clk) chk("req_ready_idle", req_ready, 1);
    @(posedge clk) #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (bad) begin
      @(negedge clk);
      chk("misalign_pulse", misalign, 1);
      chk("misalign_bus", {read, write, done}, 0);
      chk("misalign_ready", req_ready, 1);
      @(posedge clk) #1;
      @(negedge clk) chk("misalign_end", {misalign, done}, 0);
      return;
    end
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      waitrequest = c <= s;
      readdata = (!st && c == s + 2) ? rd : $urandom;
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      chk("never_both", read && write, 0);
      chk("ready_busy", req_ready, 0);
      if (c <= s + 1) begin
        chk("read", read, !st);
        chk("write", write, st);
        chk("address", address, {a[31:2], 2'b00});
        chk("byteenable", byteenable, exp_be);
        if (st) chk("writedata", writedata, exp_wd);
      end else chk("resp_idle_bus", {read, write, byteenable}, 0);
      @(posedge clk) #1;
    end
    chk("done_latency", lat, st ? s + 2 : s + 3);
    if (!st) chk("load_data", load_data, exp_ld);
    waitrequest = 1'b0;
    @(posedge clk) #1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {done, misalign, read, write, byteenable}, 0);
    chk("reset_load_data", load_data, 0);
    chk("reset_address", address, 0);
    chk("reset_writedata", writedata, 0);
    @(posedge clk) #1 reset_n = 1'b1;
    @(negedge clk) chk("ready_after_reset", req_ready, 1);
    xfer(3'd5, 32'h104, 32'hDEADBEEF, 0, 0);
    xfer(3'd7, 32'h107, 32'h0000_00A5, 0, 0);
    xfer(3'd3, 32'h107, 0, 32'hA500_0000, 0);
    chk("lb_const", load_data, 32'hFFFF_FFA5);
    xfer(3'd4, 32'h107, 0, 32'hA500_0000, 0);
    chk("lbu_const", load_data, 32'h0000_00A5);
    xfer(3'd1, 32'h102, 0, 32'h8001_0000, 0);
    chk("lh_const", load_data, 32'hFFFF_8001);
    xfer(3'd2, 32'h102, 0, 32'h8001_0000, 0);
    chk("lhu_const", load_data, 32'h0000_8001);
    xfer(3'd0, 32'h200, 0, 32'h1234_5678, 0);
    xfer(3'd0, 32'h200, 0, 32'h8765_4321, 3);
    xfer(3'd0, 32'h202, 32'h5555_5555, 0, 0);
    xfer(3'd6, 32'h101, 32'h5555_5555, 0, 0);
    @(posedge clk) #1;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h300; waitrequest = 1'b1;
    @(posedge clk) #1 req_valid = 1'b0;
    @(posedge clk) #1 reset_n = 1'b0;
    @(posedge clk) #1 reset_n = 1'b1;
    @(negedge clk) chk("reset_abort_bus", {read, write, done}, 0);
    waitrequest = 1'b0;
    repeat (4) begin
      @(negedge clk) chk("reset_abort_no_done", done, 0);
    end
    xfer(3'd5, 32'h400, 32'hCAFE_F00D, 0, 0);
    repeat (40) xfer(3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
